// File: rtl/ram_line_streamer_if.sv
// Command, buffer read port and output stream signals of ram_line_streamer.
// master = the streamer, slave = the command source / line buffer / consumer side.
interface ram_line_streamer_if #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 13
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;

    logic              ram_r_en;
    logic [ADDR_W-1:0] ram_r_addr;
    logic [DATA_W-1:0] ram_r_data;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    logic              busy;
    logic              done;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, ram_r_data, out_ready,
        output cmd_ready, ram_r_en, ram_r_addr, out_valid, out_data, out_last, busy, done
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, ram_r_data, out_ready,
        input  cmd_ready, ram_r_en, ram_r_addr, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/ram_line_streamer.sv
// Streams a run of lines from the line buffer read port as a valid/ready stream with last.
// Optional RAM_LINE_STREAMER_BOUND_EN adds err and rejects commands running past the buffer end.
module ram_line_streamer #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 13
) (
    input  logic clk,
    input  logic rst_n,
`ifdef RAM_LINE_STREAMER_BOUND_EN
    output logic err,
`endif
    ram_line_streamer_if.master bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] rd_addr;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  beats_left;
    logic              inflight;

    logic [DATA_W-1:0] fifo_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        fifo_count;

    logic              cmd_fire;
    logic              go_run;
    logic              pop;
    logic [2:0]        credit;
    logic              issue;

    assign cmd_fire = bus.cmd_valid && (state == S_IDLE);
    assign pop      = bus.out_valid && bus.out_ready;

    // Slots left once the in-flight read lands, counting the one freed by this cycle's pop.
    assign credit = 3'd2 - {1'b0, fifo_count} - {2'b0, inflight} + {2'b0, pop};
    assign issue  = (state == S_RUN) && (remaining != '0) && (credit != 3'd0);

`ifdef RAM_LINE_STREAMER_BOUND_EN
    localparam logic [LEN_W:0] DEPTH_L = (LEN_W+1)'(1 << ADDR_W);
    logic [LEN_W:0] end_line;
    logic           oob;
    assign end_line = (LEN_W+1)'(bus.cmd_addr) + (LEN_W+1)'(bus.cmd_len);
    assign oob      = end_line > DEPTH_L;
    assign go_run   = (bus.cmd_len != '0) && !oob;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else        err <= cmd_fire && oob;
    end
`else
    assign go_run = (bus.cmd_len != '0);
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rd_addr    <= '0;
            remaining  <= '0;
            beats_left <= '0;
            inflight   <= 1'b0;
        end else begin
            inflight <= issue;
            case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        rd_addr    <= bus.cmd_addr;
                        remaining  <= bus.cmd_len;
                        beats_left <= bus.cmd_len;
                        state      <= go_run ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        rd_addr   <= rd_addr + ADDR_W'(1);
                        remaining <= remaining - LEN_W'(1);
                    end
                    if (pop) begin
                        beats_left <= beats_left - LEN_W'(1);
                        if (bus.out_last) state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (inflight) wr_ptr <= ~wr_ptr;
            if (pop)      rd_ptr <= ~rd_ptr;
            fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
        end
    end

    // NOTE: storage is not reset; out_data is gated by occupancy so stale entries never show.
    always_ff @(posedge clk) begin
        if (inflight) fifo_mem[wr_ptr] <= bus.ram_r_data;
    end

    assign bus.ram_r_en   = issue;
    assign bus.ram_r_addr = rd_addr;
    assign bus.out_valid  = (fifo_count != 2'd0);
    assign bus.out_data   = bus.out_valid ? fifo_mem[rd_ptr] : '0;
    assign bus.out_last   = bus.out_valid && (beats_left == LEN_W'(1));
    assign bus.cmd_ready  = (state == S_IDLE);
    assign bus.busy       = (state != S_IDLE);
    assign bus.done       = (state == S_DONE);
endmodule

// File: tb/tb_ram_line_streamer.sv
// Randomised directed bench for ram_line_streamer: buffer contents and stalls come from $urandom,
// expected beats come from a queue of buffer lines built from the command's start and length.
`timescale 1ns/1ps
module tb_ram_line_streamer;
    localparam int DATA_W = 512;
    localparam int ADDR_W = 12;
    localparam int LEN_W  = 13;
    localparam int DEPTH  = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_line_streamer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

`ifdef RAM_LINE_STREAMER_BOUND_EN
    logic err;
`endif

    ram_line_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef RAM_LINE_STREAMER_BOUND_EN
        .err   (err),
`endif
        .bus   (bus)
    );

    // Line buffer with one-cycle read latency.
    logic [DATA_W-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (bus.ram_r_en) bus.ram_r_data <= ram[bus.ram_r_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cmd_ready"}, bus.cmd_ready, 1'b1);
        check({tag, "_ram_r_en"}, bus.ram_r_en, 1'b0);
        check({tag, "_ram_r_addr"}, bus.ram_r_addr, '0);
        check({tag, "_out_valid"}, bus.out_valid, 1'b0);
        check({tag, "_out_last"}, bus.out_last, 1'b0);
        check({tag, "_out_data"}, bus.out_data, '0);
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_done"}, bus.done, 1'b0);
`ifdef RAM_LINE_STREAMER_BOUND_EN
        check({tag, "_err"}, err, 1'b0);
`endif
    endtask

    // mode 0: out_ready always high (exact timing checked); 1: ready pattern 1,0,0; 2: random ready.
    // abort_after > 0 returns once that many beats have been accepted.
    task automatic run_cmd(input int a, input int n, input int mode, input int abort_after);
        logic [DATA_W-1:0] exp_q[$];
        int                exp_addr_q[$];
        logic [DATA_W-1:0] held;
        bit                oob, degen, stalled, pop;
        int                issued, accepted, done_cyc, limit;

        oob = 1'b0;
`ifdef RAM_LINE_STREAMER_BOUND_EN
        oob = (a + n) > DEPTH;
`endif
        degen = (n == 0) || oob;
        if (!degen) begin
            for (int i = 0; i < n; i++) begin
                exp_addr_q.push_back((a + i) % DEPTH);
                exp_q.push_back(ram[(a + i) % DEPTH]);
            end
        end
        issued = 0; accepted = 0; done_cyc = -1; stalled = 1'b0; held = '0;
        limit = 4 * n + 20;

        check("cmd_ready_before_cmd", bus.cmd_ready, 1'b1);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = ADDR_W'(a);
        bus.cmd_len   = LEN_W'(n);
        bus.out_ready = 1'b1;

        for (int cyc = 1; cyc <= limit; cyc++) begin
            @(posedge clk);
            #1;
            if (done_cyc >= 0) begin
                check("cmd_ready_after_done", bus.cmd_ready, 1'b1);
                check("done_single_pulse", bus.done, 1'b0);
                check("reads_issued", issued, exp_addr_q.size());
                check("beats_delivered", accepted, exp_q.size());
                return;
            end
            // Junk commands while busy must be ignored; drop valid once done shows.
            if (bus.done) begin
                bus.cmd_valid = 1'b0;
            end else begin
                bus.cmd_valid = 1'b1;
                bus.cmd_addr  = ADDR_W'($urandom);
                bus.cmd_len   = LEN_W'($urandom_range(0, 30));
            end
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ((cyc - 1) % 3 == 0);
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;

            if (cyc == 1) begin
                check("busy_cycle1", bus.busy, 1'b1);
                check("cmd_ready_cycle1", bus.cmd_ready, 1'b0);
            end
            if (mode == 0) begin
                check("rd_en_timing", bus.ram_r_en, !degen && cyc <= n);
                check("valid_timing", bus.out_valid, !degen && cyc >= 3 && cyc <= n + 2);
            end
            if (bus.ram_r_en) begin
                if (issued < exp_addr_q.size()) check("rd_addr", bus.ram_r_addr, exp_addr_q[issued]);
                else                            check("read_count", issued + 1, exp_addr_q.size());
                issued++;
            end
            if (stalled) begin
                check("stall_valid", bus.out_valid, 1'b1);
                check("stall_data", bus.out_data, held);
            end
            if (bus.out_valid) begin
                if (accepted < exp_q.size()) begin
                    check("out_data", bus.out_data, exp_q[accepted]);
                    check("out_last", bus.out_last, accepted == exp_q.size() - 1);
                end else begin
                    check("beat_count", accepted + 1, exp_q.size());
                end
            end else begin
                check("last_without_valid", bus.out_last, 1'b0);
            end
            pop = bus.out_valid && bus.out_ready;
            if (pop) accepted++;
            check("occupancy_le_2", (issued - accepted) <= 2, 1'b1);
            stalled = bus.out_valid && !bus.out_ready;
            held    = bus.out_data;
`ifdef RAM_LINE_STREAMER_BOUND_EN
            check("err_pulse", err, bus.done && oob);
`endif
            if (bus.done) begin
                check("done_beats", accepted, exp_q.size());
                if (mode == 0) check("done_cycle", cyc, degen ? 1 : n + 3);
                done_cyc = cyc;
            end
            if (abort_after > 0 && accepted >= abort_after) begin
                bus.cmd_valid = 1'b0;
                return;
            end
        end
        check("completed_within_budget", done_cyc >= 0, 1'b1);
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        int a;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            for (int w = 0; w < DATA_W / 32; w++)
                ram[i][w*32 +: 32] = $urandom;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;

        run_cmd(32'h010, 4, 0, 0);
        run_cmd(int'($urandom_range(0, 4000)), 8, 1, 0);
        run_cmd(32'hFFE, 4, 0, 0);
        run_cmd(int'($urandom_range(0, 4095)), 0, 0, 0);
        run_cmd(32'hFFF, 1, 0, 0);
        run_cmd(int'($urandom_range(0, 4000)), 12, 0, 0);

        for (int k = 0; k < 6; k++)
            run_cmd(int'($urandom_range(0, 4095)), int'($urandom_range(1, 20)), 2, 0);

        a = int'($urandom_range(0, 4000));
        run_cmd(a, 10, 0, 3);
        rst_n = 1'b0;
        #1;
        check_reset("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_cmd(int'($urandom_range(0, 4000)), 2, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
